// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner
//
// Conditions two raw, asynchronous and possibly bouncy request lines for a
// downstream SR flip-flop. Each line is synchronised by two flops and then
// debounced. A rising edge is accepted only after DEBOUNCE_CYCLES consecutive
// high samples. An accepted rising edge becomes a registered one-cycle S or R
// pulse. The output stage never drives S and R high together. If both
// channels qualify in the same cycle, R wins and conflict is flagged.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronised samples needed to accept a level
//                    change (legal range 1..255)
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   set_raw    asynchronous set request
//   reset_raw  asynchronous reset request
//   S          one-cycle set pulse
//   R          one-cycle reset pulse
//   conflict   one-cycle flag: both channels qualified in the same cycle
//   busy       either channel is mid-debounce (WAIT_HI or WAIT_LO)
//   conflict_count (only with SR_CONFLICT_COUNT_EN defined)
//              8-bit saturating count of cycles with conflict high
//
// Build option: define SR_CONFLICT_COUNT_EN to add the conflict_count output.

module sr_cmd_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_raw,
  input  logic       reset_raw,
  output logic       S,
  output logic       R,
  output logic       conflict,
`ifdef SR_CONFLICT_COUNT_EN
  output logic [7:0] conflict_count,
`endif
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntZero = '0;

  // Channel 0 is the set request, channel 1 is the reset request.
  localparam int unsigned ChSet = 0;
  localparam int unsigned ChRst = 1;

  typedef enum logic [1:0] {
    StIdleLo   = 2'd0,
    StWaitHi   = 2'd1,
    StStableHi = 2'd2,
    StWaitLo   = 2'd3
  } ch_state_e;

  logic [1:0] raw;
  assign raw = {reset_raw, set_raw};

  // Two-flop synchronisers. Only s2 is used by the debounce logic.
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;

  // Per-channel debounce state.
  ch_state_e        state_q [2];
  ch_state_e        state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       evt_q, evt_d;

  // Output stage.
  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;
  logic busy_q, busy_d;

`ifdef SR_CONFLICT_COUNT_EN
  logic [7:0] conflict_count_q, conflict_count_d;
`endif

  // ---------------------------------------------------------------------------
  // Synchroniser next state
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
  end

  // ---------------------------------------------------------------------------
  // Debounce FSMs, one per channel, identical
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic [CNT_W-1:0] cnt_inc;
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      evt_d[i]   = 1'b0;
      cnt_inc    = cnt_q[i] + CntOne;

      unique case (state_q[i])
        StIdleLo: begin
          if (s2_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // One sample is already a full qualification.
              state_d[i] = StStableHi;
              cnt_d[i]   = CntZero;
              evt_d[i]   = 1'b1;
            end else begin
              state_d[i] = StWaitHi;
              cnt_d[i]   = CntOne;
            end
          end
        end

        StWaitHi: begin
          if (!s2_q[i]) begin
            state_d[i] = StIdleLo;
            cnt_d[i]   = CntZero;
          end else if (cnt_inc == CntMax) begin
            state_d[i] = StStableHi;
            cnt_d[i]   = CntZero;
            evt_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_inc;
          end
        end

        StStableHi: begin
          if (!s2_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i] = StIdleLo;
              cnt_d[i]   = CntZero;
            end else begin
              state_d[i] = StWaitLo;
              cnt_d[i]   = CntOne;
            end
          end
        end

        StWaitLo: begin
          if (s2_q[i]) begin
            // The low was not qualified, so the line is still high. No new event.
            state_d[i] = StStableHi;
            cnt_d[i]   = CntZero;
          end else if (cnt_inc == CntMax) begin
            state_d[i] = StIdleLo;
            cnt_d[i]   = CntZero;
          end else begin
            cnt_d[i] = cnt_inc;
          end
        end

        default: begin
          state_d[i] = StIdleLo;
          cnt_d[i]   = CntZero;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: reset request wins a same-cycle collision
  // ---------------------------------------------------------------------------
  always_comb begin
    s_d        = evt_q[ChSet] & ~evt_q[ChRst];
    r_d        = evt_q[ChRst];
    conflict_d = evt_q[ChSet] & evt_q[ChRst];
    // Built from next state so that busy lines up with the state registers.
    busy_d     = (state_d[ChSet] == StWaitHi) || (state_d[ChSet] == StWaitLo) ||
                 (state_d[ChRst] == StWaitHi) || (state_d[ChRst] == StWaitLo);
  end

`ifdef SR_CONFLICT_COUNT_EN
  always_comb begin
    conflict_count_d = conflict_count_q;
    if (conflict_q && (conflict_count_q != 8'hff)) begin
      conflict_count_d = conflict_count_q + 8'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      state_q[0] <= StIdleLo;
      state_q[1] <= StIdleLo;
      cnt_q[0]   <= CntZero;
      cnt_q[1]   <= CntZero;
      evt_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      evt_q      <= evt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      busy_q     <= busy_d;
    end
  end

`ifdef SR_CONFLICT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_count_q <= 8'd0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign conflict_count = conflict_count_q;
`endif

  assign S        = s_q;
  assign R        = r_q;
  assign conflict = conflict_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed testbench for sr_cmd_conditioner with DEBOUNCE_CYCLES = 4.
// Tick index t counts rising edges after an input change. t = 1 is the edge
// that first samples the new level. With a steady input, the pulse is
// therefore expected at t = 7 (DEBOUNCE_CYCLES + 2 edges later).

module tb_sr_cmd_conditioner;

  logic clk;
  logic rst;
  logic set_raw;
  logic reset_raw;
  logic S;
  logic R;
  logic conflict;
  logic busy;
`ifdef SR_CONFLICT_COUNT_EN
  logic [7:0] conflict_count;
`endif

  int tests;
  int fails;

  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .set_raw        (set_raw),
    .reset_raw      (reset_raw),
    .S              (S),
    .R              (R),
    .conflict       (conflict),
`ifdef SR_CONFLICT_COUNT_EN
    .conflict_count (conflict_count),
`endif
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n edges and record what the outputs did.
  task automatic observe(input int n, output int s_cnt, output int r_cnt, output int c_cnt,
                         output int s_first, output int r_first, output int sr_both);
    s_cnt = 0; r_cnt = 0; c_cnt = 0; s_first = -1; r_first = -1; sr_both = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (S === 1'b1) begin
        s_cnt++;
        if (s_first < 0) s_first = t;
      end
      if (R === 1'b1) begin
        r_cnt++;
        if (r_first < 0) r_first = t;
      end
      if (conflict === 1'b1) c_cnt++;
      if (S === 1'b1 && R === 1'b1) sr_both++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_raw = 1'b0;
    reset_raw = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_raw = 1'b0;
    reset_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({S, R, conflict, busy} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d got SRCB=%b exp 0000", i, {S, R, conflict, busy});
      end
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({S, R, conflict, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release got SRCB=%b exp 0000", {S, R, conflict, busy});
    end
  endtask

  task automatic test_clean_set();
    logic exp_s;
    logic exp_busy;
    int s_errs;
    int b_errs;
    int r_errs;
    do_reset();
    s_errs = 0; b_errs = 0; r_errs = 0;
    set_raw = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_s    = (t == 7);
      exp_busy = (t >= 3 && t <= 5);
      if (S !== exp_s) begin
        s_errs++;
        $display("FAIL clean_rise_S t=%0d got %b exp %b", t, S, exp_s);
      end
      if (busy !== exp_busy) begin
        b_errs++;
        $display("FAIL clean_rise_busy t=%0d got %b exp %b", t, busy, exp_busy);
      end
      if (R !== 1'b0) begin
        r_errs++;
        $display("FAIL clean_rise_R t=%0d got %b exp 0", t, R);
      end
    end
    tests++; if (s_errs != 0) fails++;
    tests++; if (b_errs != 0) fails++;
    tests++; if (r_errs != 0) fails++;

    // Qualified fall: WAIT_LO for 4 samples, no event.
    s_errs = 0; b_errs = 0;
    set_raw = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp_busy = (t >= 3 && t <= 5);
      if (S !== 1'b0) begin
        s_errs++;
        $display("FAIL clean_fall_S t=%0d got %b exp 0", t, S);
      end
      if (busy !== exp_busy) begin
        b_errs++;
        $display("FAIL clean_fall_busy t=%0d got %b exp %b", t, busy, exp_busy);
      end
    end
    tests++; if (s_errs != 0) fails++;
    tests++; if (b_errs != 0) fails++;
  endtask

  task automatic test_bounce();
    int sc, rc, cc, sf, rf, bo;
    int bounce_s;
    logic [3:0] pattern;
    do_reset();
    bounce_s = 0;
    pattern = 4'b0101;  // applied LSB first: 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      set_raw = pattern[i];
      observe(1, sc, rc, cc, sf, rf, bo);
      bounce_s += sc;
    end
    tests++;
    if (bounce_s != 0) begin
      fails++;
      $display("FAIL bounce_no_S got %0d pulses exp 0", bounce_s);
    end
    set_raw = 1'b1;
    observe(20, sc, rc, cc, sf, rf, bo);
    tests++;
    if (sc != 1) begin
      fails++;
      $display("FAIL bounce_S_count got %0d exp 1", sc);
    end
    tests++;
    if (sf != 7) begin
      fails++;
      $display("FAIL bounce_S_latency got %0d exp 7", sf);
    end
  endtask

  task automatic test_conflict();
    int sc, rc, cc, sf, rf, bo;
    do_reset();
    set_raw = 1'b1;
    reset_raw = 1'b1;
    observe(20, sc, rc, cc, sf, rf, bo);
    tests++;
    if (rc != 1 || rf != 7) begin
      fails++;
      $display("FAIL conflict_R got count=%0d first=%0d exp count=1 first=7", rc, rf);
    end
    tests++;
    if (sc != 0) begin
      fails++;
      $display("FAIL conflict_S got %0d pulses exp 0", sc);
    end
    tests++;
    if (cc != 1) begin
      fails++;
      $display("FAIL conflict_flag got %0d cycles exp 1", cc);
    end
    tests++;
    if (bo != 0) begin
      fails++;
      $display("FAIL conflict_SR_both got %0d cycles exp 0", bo);
    end
`ifdef SR_CONFLICT_COUNT_EN
    tests++;
    if (conflict_count !== 8'd1) begin
      fails++;
      $display("FAIL conflict_count got %0d exp 1", conflict_count);
    end
`endif
  endtask

  task automatic test_short_low();
    int sc, rc, cc, sf, rf, bo;
    int total_r;
    do_reset();
    reset_raw = 1'b1;
    observe(10, sc, rc, cc, sf, rf, bo);
    total_r = rc;
    tests++;
    if (rf != 7 || sc != 0) begin
      fails++;
      $display("FAIL short_low_first_R got first=%0d S=%0d exp first=7 S=0", rf, sc);
    end
    reset_raw = 1'b0;
    observe(2, sc, rc, cc, sf, rf, bo);
    total_r += rc;
    reset_raw = 1'b1;
    observe(15, sc, rc, cc, sf, rf, bo);
    total_r += rc;
    tests++;
    if (total_r != 1) begin
      fails++;
      $display("FAIL short_low_R_total got %0d exp 1", total_r);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL short_low_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int sc, rc, cc, sf, rf, bo;
    do_reset();
    set_raw = 1'b1;
    observe(5, sc, rc, cc, sf, rf, bo);
    tests++;
    if (busy !== 1'b1 || sc != 0) begin
      fails++;
      $display("FAIL mid_pre_reset got busy=%b S=%0d exp busy=1 S=0", busy, sc);
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({S, R, conflict, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_in_reset got SRCB=%b exp 0000", {S, R, conflict, busy});
    end
    rst = 1'b0;
    observe(20, sc, rc, cc, sf, rf, bo);
    tests++;
    if (sc != 1 || sf != 7) begin
      fails++;
      $display("FAIL mid_restart_S got count=%0d first=%0d exp count=1 first=7", sc, sf);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    set_raw = 1'b0;
    reset_raw = 1'b0;
    test_reset();
    test_clean_set();
    test_bounce();
    test_conflict();
    test_short_low();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_cmd_conditioner.md
Name: sr_cmd_conditioner

Overview:
- Upstream feeder for the SR flip-flop stage.
- Takes two raw, asynchronous, bouncy request lines (set request, reset request).
- Synchronises and debounces each line, then emits a registered one-cycle S or R pulse on each qualified rising edge.
- Guarantees the downstream flip-flop never sees the invalid S=R=1 combination.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples at the new level needed to accept a level change. Legal range 1..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): localparam, debounce counter width. Not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- set_raw  input  1  asynchronous set request, may bounce.
- reset_raw  input  1  asynchronous reset request, may bounce.
- S  output  1  registered one-cycle set pulse to the SR flip-flop.
- R  output  1  registered one-cycle reset pulse to the SR flip-flop.
- conflict  output  1  registered one-cycle flag: both channels qualified in the same cycle.
- busy  output  1  high while either channel is in WAIT_HI or WAIT_LO.

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over every other action.
  - Clears both 2-flop synchronisers, both FSMs (to IDLE_LO), both counters, and S, R, conflict and busy to 0.
  - Reset asserted mid-debounce discards the partial count. No pulse is emitted for that edge.
- Synchroniser: each raw input passes through 2 flops (s1 then s2). Only s2 feeds the FSM.
- Per-channel FSM, one per input, identical:
  - IDLE_LO:
    - s2=1 -> WAIT_HI, cnt=1.
    - If DEBOUNCE_CYCLES=1, go directly to STABLE_HI and raise rise_evt.
  - WAIT_HI:
    - s2=0 -> IDLE_LO, cnt=0.
    - Otherwise cnt+1. When cnt reaches DEBOUNCE_CYCLES -> STABLE_HI and raise rise_evt for one cycle.
  - STABLE_HI: s2=0 -> WAIT_LO, cnt=1 (DEBOUNCE_CYCLES=1: directly to IDLE_LO).
  - WAIT_LO:
    - s2=1 -> STABLE_HI, cnt=0.
    - Otherwise cnt+1. When cnt reaches DEBOUNCE_CYCLES -> IDLE_LO.
    - No event on the falling edge.
- Counter never exceeds DEBOUNCE_CYCLES. No wrap.
- Output stage (registered, evaluated every cycle):
  - set_evt only -> S=1, R=0.
  - reset_evt only -> R=1, S=0.
  - Both -> R=1, S=0, conflict=1 (reset wins).
  - Neither -> S=R=conflict=0.
- Invariant: S and R are never 1 in the same cycle.
- Latency:
  - Input held steady high: S (or R) rises exactly DEBOUNCE_CYCLES+2 rising edges after the edge that first samples raw=1.
  - The pulse lasts exactly 1 cycle.
- A held-high input produces exactly one pulse. A new pulse requires a qualified low (full WAIT_LO) followed by a new qualified high.
- busy is a registered OR of (state==WAIT_HI or WAIT_LO) over both channels, aligned with the state registers.

Optional Feature:
- Macro: SR_CONFLICT_COUNT_EN
- Defined:
  - Adds output conflict_count, 8 bits: a saturating count of cycles where conflict=1.
  - Cleared by rst. Holds at 255.
  - Updates in the same cycle conflict is asserted, so the value is visible the cycle after conflict.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- DEBOUNCE_CYCLES=4, rst high 3 cycles -> S=R=conflict=busy=0 throughout and on the first cycle after release.
- set_raw clean rise held 20 cycles -> single S pulse of width 1, starting 6 edges after first sampling; R stays 0.
- set_raw bounces 1,0,1,0 at one-cycle intervals, then holds 1 -> no S during the bounce; one S pulse 6 edges after the final stable rise.
- set_raw and reset_raw rise on the same edge, both held -> R=1, S=0, conflict=1 for one cycle; no later S pulse. With SR_CONFLICT_COUNT_EN, conflict_count=1.
- reset_raw held high 10 cycles, low for 2 cycles (less than 4), high again -> only one R pulse total.
- set_raw held and rst asserted at edge 4 of WAIT_HI, released at edge 5 with set_raw still high -> debounce restarts; S rises 6 edges after the first post-reset sampling.
